// File: rtl/spram_pkg.sv
// Shared types for the eForth SPRAM arbiter: bus geometry, memory beat,
// arbiter state and read-return tag.
package spram_pkg;

    localparam int ASZ = 15;
    localparam int DSZ = 32;

    typedef struct packed {
        logic [ASZ-1:0] ai;
        logic [DSZ-1:0] vi;
        logic           we;
        logic [3:0]     bmsk;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_st_e;

    typedef struct packed {
        logic v;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/spram32_rdpipe.sv
// Read-return delay line: carries {valid, id} alongside the SPRAM read latency
// and steers mem_vo onto the shared response bus when the tag emerges.
module spram32_rdpipe #(
    parameter int DSZ    = 32,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tag_v,
    input  logic           tag_id,
    input  logic [DSZ-1:0] mem_vo,
    output logic [1:0]     rsp_v,
    output logic [DSZ-1:0] rsp_vo
);
    import spram_pkg::*;

    rd_tag_t        tag_p [0:RD_LAT];
    logic [DSZ-1:0] vo_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) tag_p[i] <= '0;
            vo_hold <= '0;
        end else begin
            tag_p[0] <= '{v: tag_v, id: tag_id};
            for (int i = 1; i <= RD_LAT; i++) tag_p[i] <= tag_p[i-1];
            vo_hold <= rsp_vo;
        end
    end

    // Output stage: tag lines up with the cycle mem_vo is valid
    assign rsp_v  = {tag_p[RD_LAT].v &  tag_p[RD_LAT].id,
                     tag_p[RD_LAT].v & ~tag_p[RD_LAT].id};
    assign rsp_vo = tag_p[RD_LAT].v ? mem_vo : vo_hold;

endmodule

// File: rtl/spram32_arb.sv
// Two-requester arbiter/sequencer for the shared 32K x 32 SPRAM (R0 = fetch, R1 = data).
// Build option: SPRAM_ARB_PRIO_EN selects fixed R1 priority instead of round-robin.
module spram32_arb #(
    parameter int ASZ      = 15,
    parameter int DSZ      = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_v,
    output logic [1:0]       req_rdy,
    input  logic [1:0]       req_we,
    input  logic [1:0]       req_lock,
    input  logic [2*ASZ-1:0] req_ai,
    input  logic [2*DSZ-1:0] req_vi,
    input  logic [7:0]       req_bmsk,
    output logic [1:0]       rsp_v,
    output logic [DSZ-1:0]   rsp_vo,
    output logic [ASZ-1:0]   mem_ai,
    output logic [DSZ-1:0]   mem_vi,
    output logic             mem_we,
    output logic [3:0]       mem_bmsk,
    input  logic [DSZ-1:0]   mem_vo
);
    import spram_pkg::*;

`ifdef SPRAM_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    localparam int             CW      = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_LOCK - 1);
    localparam logic [CW-1:0]  FIRST   = CW'((MAX_LOCK > 1) ? 1 : 0);

    arb_st_e       st, st_nxt;
    logic          rr_last;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;
    logic          win, acc, hand;
    mem_req_t      beat_p0, beat_p1;

    // Free-choice winner: round-robin on ties, or R1 on ties in priority builds
    function automatic logic pick(input logic [1:0] v, input logic rr);
        pick = (v == 2'b11) ? (PRIO ? 1'b1 : ~rr) : v[1];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            lock_cnt <= '0;
            rr_last  <= 1'b1;
        end else begin
            st       <= st_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (acc) rr_last <= win;
        end
    end

    always_comb begin
        st_nxt       = IDLE;
        lock_cnt_nxt = '0;
        hand         = (lock_cnt == CNT_MAX) && req_v[~win] && !(PRIO && win);
        if (acc && req_lock[win] && !hand) begin
            st_nxt = win ? OWN1 : OWN0;
            if (st != st_nxt)             lock_cnt_nxt = FIRST;
            else if (lock_cnt != CNT_MAX) lock_cnt_nxt = lock_cnt + CW'(1);
            else                          lock_cnt_nxt = lock_cnt;
        end
    end

    // A lapsed owner falls straight through to the free choice, so hand-over has no bubble
    always_comb begin
        win = pick(req_v, rr_last);
        if (st == OWN0 && req_v[0])      win = 1'b0;
        else if (st == OWN1 && req_v[1]) win = 1'b1;
        acc          = rst_n && req_v[win];
        req_rdy      = '0;
        req_rdy[win] = acc;
    end

    always_comb begin
        beat_p0.ai   = win ? req_ai[2*ASZ-1:ASZ]   : req_ai[ASZ-1:0];
        beat_p0.vi   = win ? req_vi[2*DSZ-1:DSZ]   : req_vi[DSZ-1:0];
        beat_p0.we   = req_we[win];
        beat_p0.bmsk = win ? req_bmsk[7:4]         : req_bmsk[3:0];
    end

    // Stage p0 -> p1: accepted beat drives the SPRAM bus next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_p1 <= '0;
        end else begin
            beat_p1.we <= 1'b0;
            if (acc) beat_p1 <= beat_p0;
        end
    end

    assign mem_ai   = beat_p1.ai;
    assign mem_vi   = beat_p1.vi;
    assign mem_we   = beat_p1.we;
    assign mem_bmsk = beat_p1.bmsk;

    spram32_rdpipe #(
        .DSZ    (DSZ),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_v  (acc && !req_we[win]),
        .tag_id (win),
        .mem_vo (mem_vo),
        .rsp_v  (rsp_v),
        .rsp_vo (rsp_vo)
    );

endmodule

// File: tb/tb_spram32_arb.sv
// Scoreboard bench for spram32_arb with a behavioural 1-cycle-latency SPRAM model.
module tb_spram32_arb;
    localparam int ASZ = 15;
    localparam int DSZ = 32;
`ifdef SPRAM_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       req_v, req_rdy, req_we, req_lock, rsp_v;
    logic [2*ASZ-1:0] req_ai;
    logic [2*DSZ-1:0] req_vi;
    logic [7:0]       req_bmsk;
    logic [DSZ-1:0]   rsp_vo, mem_vi, mem_vo;
    logic [ASZ-1:0]   mem_ai;
    logic             mem_we;
    logic [3:0]       mem_bmsk;

    always #5 clk = ~clk;

    spram32_arb #(.ASZ(ASZ), .DSZ(DSZ), .RD_LAT(1), .MAX_LOCK(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_v(req_v), .req_rdy(req_rdy), .req_we(req_we),
        .req_lock(req_lock), .req_ai(req_ai), .req_vi(req_vi), .req_bmsk(req_bmsk),
        .rsp_v(rsp_v), .rsp_vo(rsp_vo), .mem_ai(mem_ai), .mem_vi(mem_vi),
        .mem_we(mem_we), .mem_bmsk(mem_bmsk), .mem_vo(mem_vo)
    );

    // SPRAM model: byte-masked write, registered read one cycle after address
    logic [DSZ-1:0] mem [0:32767];
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        mem_vo = '0;
    end
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_bmsk[b]) mem[mem_ai][8*b +: 8] <= mem_vi[8*b +: 8];
        mem_vo <= mem[mem_ai];
    end

    typedef struct {
        logic [1:0]  oh;
        logic [31:0] d;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response appears
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0 && q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_missing: got no rsp_v by cycle %0d expected %b at cycle %0d",
                     cyc, q[0].oh, q[0].cyc);
            void'(q.pop_front());
        end
        if (rsp_v != 2'b00) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_v), 64'(0));
            end else begin
                e = q.pop_front();
                chk("rsp_v",     64'(rsp_v),  64'(e.oh));
                chk("rsp_vo",    64'(rsp_vo), 64'(e.d));
                chk("rsp_cycle", 64'(cyc),    64'(e.cyc));
            end
        end
    end

    // One cycle of stimulus; d0/d1 are write data, or expected read data for reads
    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [14:0] a0, input logic [14:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [3:0] m0, input logic [3:0] m1,
                        input logic [1:0] erdy, input string nm);
        @(posedge clk);
        #1;
        req_v    = v;
        req_we   = we;
        req_lock = lk;
        req_ai   = {a1, a0};
        req_vi   = {d1, d0};
        req_bmsk = {m1, m0};
        @(negedge clk);
        chk(nm, 64'(req_rdy), 64'(erdy));
        for (int i = 0; i < 2; i++)
            if (erdy[i] && !we[i])
                q.push_back('{oh: 2'(1 << i), d: (i == 1) ? d1 : d0, cyc: cyc + 2});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, "idle_rdy");
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_req_rdy"},  64'(req_rdy),  64'(0));
        chk({tag, "_rsp_v"},    64'(rsp_v),    64'(0));
        chk({tag, "_rsp_vo"},   64'(rsp_vo),   64'(0));
        chk({tag, "_mem_we"},   64'(mem_we),   64'(0));
        chk({tag, "_mem_ai"},   64'(mem_ai),   64'(0));
        chk({tag, "_mem_vi"},   64'(mem_vi),   64'(0));
        chk({tag, "_mem_bmsk"}, 64'(mem_bmsk), 64'(0));
    endtask

    initial begin
        logic [1:0] er;
        int n0, n1;
        req_v = 2'b11; req_we = '0; req_lock = '0; req_ai = '0; req_vi = '0; req_bmsk = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_vals("rst0");
        req_v = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // R0 alone: write then read back
        step(2'b01, 2'b01, 2'b00, 15'h0010, 0, 32'hDEADBEEF, 0, 4'hF, 0, 2'b01, "t1_wr");
        step(2'b01, 2'b00, 2'b00, 15'h0010, 0, 32'hDEADBEEF, 0, 4'h0, 0, 2'b01, "t1_rd");
        idle(1);

        // Preload two tables via R1, then both read every cycle
        for (int i = 0; i < 8; i++) begin
            step(2'b10, 2'b10, 2'b00, 0, 15'(16'h100 + i), 0, 32'hC0DE0100 + i, 0, 4'hF, 2'b10, "t2_pre_a");
            step(2'b10, 2'b10, 2'b00, 0, 15'(16'h200 + i), 0, 32'hC0DE0200 + i, 0, 4'hF, 2'b10, "t2_pre_b");
        end
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            er = PRIO ? 2'b10 : ((k % 2 == 0) ? 2'b01 : 2'b10);
            step(2'b11, 2'b00, 2'b00, 15'(16'h100 + n0), 15'(16'h200 + n1),
                 32'hC0DE0100 + n0, 32'hC0DE0200 + n1, 0, 0, er, "t2_alt");
            if (er[0]) n0++;
            if (er[1]) n1++;
        end
        idle(1);

        // R1 locked burst of 20 beats with R0 pending from beat 2
        step(2'b10, 2'b00, 2'b10, 0, 15'h200, 0, 32'hC0DE0200, 0, 0, 2'b10, "t3_own");
        for (int k = 1; k <= 20; k++) begin
            er = (!PRIO && k == 16) ? 2'b01 : 2'b10;
            step(2'b11, 2'b00, 2'b10, 15'h100, 15'h201, 32'hC0DE0100, 32'hC0DE0201, 0, 0, er, "t3_lock");
        end
        step(2'b01, 2'b00, 2'b00, 15'h101, 0, 32'hC0DE0101, 0, 0, 0, 2'b01, "t3_release");
        idle(1);

        // Byte mask and back-to-back read-after-write
        step(2'b01, 2'b01, 2'b00, 15'h7fff, 0, 32'hFFFFFFFF, 0, 4'hF,    0, 2'b01, "t4_wr_full");
        step(2'b01, 2'b01, 2'b00, 15'h7fff, 0, 32'h00000000, 0, 4'b0011, 0, 2'b01, "t4_wr_mask");
        step(2'b01, 2'b00, 2'b00, 15'h7fff, 0, 32'hFFFF0000, 0, 4'h0,    0, 2'b01, "t4_rd");
        idle(3);

        // Reset with two reads in flight
        step(2'b10, 2'b00, 2'b00, 0, 15'h100, 0, 32'hC0DE0100, 0, 0, 2'b10, "t5_rd1");
        step(2'b01, 2'b00, 2'b00, 15'h7fff, 0, 32'hFFFF0000, 0, 0, 0, 2'b01, "t5_rd2");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        req_v = 2'b11; req_we = 2'b00; req_lock = 2'b00;
        #1;
        reset_vals("rst1");
        repeat (3) @(negedge clk);
        req_v = 2'b00;
        rst_n = 1'b1;
        step(2'b11, 2'b00, 2'b00, 15'h100, 15'h200, 32'hC0DE0100, 32'hC0DE0200, 0, 0,
             PRIO ? 2'b10 : 2'b01, "t5_tie");
        idle(3);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        chk("drain_pending", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
